// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer commit controller: retires the ROB head in program order,
// sequences memory operations through MEM_WAIT and redirects on mispredicts.
module rob_commit_ctrl #(
  parameter int TAG_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [1:0]           head_type,
  input  logic [4:0]           head_rd,
  input  logic [TAG_WIDTH-1:0] head_tag,
  input  logic                 head_mispredict,
  input  logic                 data_mem_resp,
  output logic                 commit,
  output logic [TAG_WIDTH-1:0] commit_tag,
  output logic                 regfile_load,
  output logic [4:0]           regfile_rd,
  output logic                 ld_commit_sel,
  output logic                 data_read,
  output logic                 data_write,
  output logic                 flush,
  output logic                 load_pc,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] T_ALU    = 2'b00;
  localparam logic [1:0] T_LOAD   = 2'b01;
  localparam logic [1:0] T_STORE  = 2'b10;
  localparam logic [1:0] T_BRANCH = 2'b11;

  state_t                 state_q, state_d;
  logic [4:0]             rd_q, rd_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   is_load_q, is_load_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   accept_s;
  logic                   is_mem_s;
  logic                   commit_s;
  logic [TAG_WIDTH-1:0]   tag_s;
  logic                   rl_s;
  logic [4:0]             rd_s;
  logic                   sel_s;
  logic                   read_s;
  logic                   write_s;
  logic                   flush_s;
  logic                   lpc_s;

  assign accept_s = (state_q == IDLE) && head_valid && head_ready;
  assign is_mem_s = (head_type == T_LOAD) || (head_type == T_STORE);

  // State, memory-op latches and retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= 5'd0;
      tag_q     <= {TAG_WIDTH{1'b0}};
      is_load_q <= 1'b0;
      cnt_q     <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and latch capture.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    is_load_d = is_load_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (head_type)
            T_LOAD, T_STORE: begin
              state_d   = MEM_WAIT;
              rd_d      = head_rd;
              tag_d     = head_tag;
              is_load_d = (head_type == T_LOAD);
            end
            T_BRANCH: begin
              if (head_mispredict) begin
                state_d = FLUSH;
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        if (data_mem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit strobes: Mealy on the accepted head in IDLE, Moore request in MEM_WAIT.
  always_comb begin
    commit_s = 1'b0;
    tag_s    = head_tag;
    rl_s     = 1'b0;
    rd_s     = 5'd0;
    sel_s    = 1'b0;
    read_s   = 1'b0;
    write_s  = 1'b0;
    flush_s  = 1'b0;
    lpc_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && !is_mem_s) begin
          commit_s = 1'b1;
          rl_s     = (head_rd != 5'd0);
          rd_s     = head_rd;
          if ((head_type == T_BRANCH) && head_mispredict) begin
            flush_s = 1'b1;
            lpc_s   = 1'b1;
          end else begin
            flush_s = 1'b0;
            lpc_s   = 1'b0;
          end
        end else begin
          commit_s = 1'b0;
        end
      end
      MEM_WAIT: begin
        tag_s   = tag_q;
        read_s  = is_load_q;
        write_s = !is_load_q;
        if (data_mem_resp) begin
          commit_s = 1'b1;
          if (is_load_q) begin
            rl_s  = (rd_q != 5'd0);
            rd_s  = rd_q;
            sel_s = 1'b1;
          end else begin
            rl_s  = 1'b0;
          end
        end else begin
          commit_s = 1'b0;
        end
      end
      FLUSH:   tag_s = {TAG_WIDTH{1'b0}};
      default: tag_s = {TAG_WIDTH{1'b0}};
    endcase
  end

  assign cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, commit};

  // Reset masks the architectural side effects within the same cycle.
  assign commit        = commit_s & ~rst;
  assign regfile_load  = rl_s & ~rst;
  assign flush         = flush_s & ~rst;
  assign load_pc       = lpc_s & ~rst;
  assign commit_tag    = tag_s;
  assign regfile_rd    = rd_s;
  assign ld_commit_sel = sel_s;
  assign data_read     = read_s;
  assign data_write    = write_s;
  assign busy          = (state_q != IDLE);
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed scoreboard bench for rob_commit_ctrl.
module tb_rob_commit_ctrl;

  localparam logic [1:0] ALU = 2'b00, LD = 2'b01, ST = 2'b10, BR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid, head_ready, head_mispredict, data_mem_resp;
  logic [1:0]  head_type;
  logic [4:0]  head_rd;
  logic [2:0]  head_tag;
  logic        commit, regfile_load, ld_commit_sel, data_read, data_write;
  logic        flush, load_pc, busy;
  logic [2:0]  commit_tag;
  logic [4:0]  regfile_rd;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  rob_commit_ctrl #(.TAG_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
    .head_rd(head_rd), .head_tag(head_tag), .head_mispredict(head_mispredict),
    .data_mem_resp(data_mem_resp),
    .commit(commit), .commit_tag(commit_tag), .regfile_load(regfile_load),
    .regfile_rd(regfile_rd), .ld_commit_sel(ld_commit_sel),
    .data_read(data_read), .data_write(data_write), .flush(flush),
    .load_pc(load_pc), .busy(busy), .retired_count(retired_count)
  );

  typedef struct {
    logic        c;
    logic [2:0]  t;
    logic        tc;
    logic        rl;
    logic [4:0]  rd;
    logic        sel;
    logic        rc;
    logic        dr;
    logic        dw;
    logic        fl;
    logic        lp;
    logic        bz;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic c, input logic [2:0] t, input logic tc,
                      input logic rl, input logic [4:0] rd, input logic sel,
                      input logic rc, input logic dr, input logic dw,
                      input logic fl, input logic lp, input logic bz);
    exp_t e;
    e.c = c; e.t = t; e.tc = tc; e.rl = rl; e.rd = rd; e.sel = sel; e.rc = rc;
    e.dr = dr; e.dw = dw; e.fl = fl; e.lp = lp; e.bz = bz; e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (c) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic push_idle(input logic bz);
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bz);
  endtask

  task automatic head(input logic v, input logic r, input logic [1:0] ty,
                      input logic [4:0] rd, input logic [2:0] tag, input logic mp);
    head_valid = v; head_ready = r; head_type = ty;
    head_rd = rd; head_tag = tag; head_mispredict = mp;
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic step(input string name);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".commit"}, {15'd0, commit}, {15'd0, e.c});
      if (e.tc) chk({name, ".commit_tag"}, {13'd0, commit_tag}, {13'd0, e.t});
      chk({name, ".regfile_load"}, {15'd0, regfile_load}, {15'd0, e.rl});
      if (e.rc) begin
        chk({name, ".regfile_rd"}, {11'd0, regfile_rd}, {11'd0, e.rd});
        chk({name, ".ld_commit_sel"}, {15'd0, ld_commit_sel}, {15'd0, e.sel});
      end
      chk({name, ".data_read"}, {15'd0, data_read}, {15'd0, e.dr});
      chk({name, ".data_write"}, {15'd0, data_write}, {15'd0, e.dw});
      chk({name, ".rw_excl"}, {15'd0, data_read & data_write}, 16'd0);
      chk({name, ".flush"}, {15'd0, flush}, {15'd0, e.fl});
      chk({name, ".load_pc"}, {15'd0, load_pc}, {15'd0, e.lp});
      chk({name, ".busy"}, {15'd0, busy}, {15'd0, e.bz});
      chk({name, ".retired_count"}, retired_count, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    data_mem_resp = 1'b0;
    head(1'b0, 1'b0, ALU, 5'd0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    push_idle(1'b0);                                          step("reset");
    rst = 1'b0;

    // ALU commits, stalled head
    head(1'b1, 1'b1, ALU, 5'd5, 3'd2, 1'b0);
    push(1'b1, 3'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("alu");
    head(1'b1, 1'b0, ALU, 5'd6, 3'd3, 1'b0);
    push_idle(1'b0);                                          step("not_ready");
    head(1'b1, 1'b1, ALU, 5'd0, 3'd3, 1'b0);
    push(1'b1, 3'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("alu_rd0");

    // LOAD with resp on the third request cycle; next head waits behind it
    head(1'b1, 1'b1, LD, 5'd7, 3'd4, 1'b0);
    push_idle(1'b0);                                          step("ld_acc");
    head(1'b0, 1'b0, ALU, 5'd0, 3'd0, 1'b0);
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("ld_w1");
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("ld_w2");
    data_mem_resp = 1'b1;
    head(1'b1, 1'b1, ALU, 5'd3, 3'd5, 1'b0);
    push(1'b1, 3'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("ld_resp");
    data_mem_resp = 1'b0;
    push(1'b1, 3'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("post_mem_alu");

    // STORE rd=0 with head changed mid-wait
    head(1'b1, 1'b1, ST, 5'd0, 3'd6, 1'b0);
    push_idle(1'b0);                                          step("st_acc");
    head(1'b1, 1'b1, LD, 5'd9, 3'd1, 1'b0);
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); step("st_w1");
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); step("st_w2");
    data_mem_resp = 1'b1;
    push(1'b1, 3'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); step("st_resp");
    head(1'b0, 1'b0, ALU, 5'd0, 3'd0, 1'b0);
    push_idle(1'b0);                                          step("resp_in_idle");
    data_mem_resp = 1'b0;

    // Mispredicted branch, flush cycle, re-accept
    head(1'b1, 1'b1, BR, 5'd1, 3'd3, 1'b1);
    push(1'b1, 3'd3, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step("br_mp");
    data_mem_resp = 1'b1;
    push_idle(1'b1);                                          step("flush_cycle");
    data_mem_resp = 1'b0;
    head(1'b1, 1'b1, BR, 5'd1, 3'd3, 1'b0);
    push(1'b1, 3'd3, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("br_again");

    // Reset while waiting on a load, resp afterwards
    head(1'b1, 1'b1, LD, 5'd8, 3'd7, 1'b0);
    push_idle(1'b0);                                          step("ld2_acc");
    head(1'b0, 1'b0, ALU, 5'd0, 3'd0, 1'b0);
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("ld2_w1");
    rst = 1'b1;
    data_mem_resp = 1'b1;
    push(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step("rst_midwait");
    rst = 1'b0;
    exp_cnt = 16'd0;
    push_idle(1'b0);                                          step("post_rst_resp");
    data_mem_resp = 1'b0;
    push_idle(1'b0);                                          step("post_rst");

    // Counter wrap after 2^16 commits
    head(1'b1, 1'b1, ALU, 5'd2, 3'd0, 1'b0);
    repeat (65535) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFF;
    push(1'b1, 3'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("wrap_last");
    head(1'b0, 1'b0, ALU, 5'd0, 3'd0, 1'b0);
    push_idle(1'b0);                                          step("wrapped");

    chk("scoreboard_drained", sb_q.size(), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
